// File: rtl/add_sub_pkg.sv
// Shared types and constants for the sliced add/sub sequencer.
package add_sub_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_alu.sv
// One W-bit add/subtract slice; b is inverted internally when op=1.
module nibble_alu
  import add_sub_pkg::*;
#(
  parameter int unsigned W = SLICE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         op,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf
);

  logic [W-1:0] bx;
  logic [W:0]   sum;

  assign bx   = b ^ {W{op}};
  assign sum  = (W+1)'(a) + (W+1)'(bx) + (W+1)'(cin);
  assign s    = sum[W-1:0];
  assign cout = sum[W];
  // carry into the MSB is recovered from the MSB sum bit and its operands
  assign ovf  = a[W-1] ^ bx[W-1] ^ sum[W-1] ^ sum[W];

endmodule

// File: rtl/add_sub_seq.sv
// Wide add/subtract computed one slice per clock, LSB first, on a single shared ALU slice.
module add_sub_seq
  import add_sub_pkg::*;
#(
  parameter int unsigned W     = SLICE_W,
  parameter int unsigned WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op,
  input  logic [W*WORDS-1:0] a,
  input  logic [W*WORDS-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [W*WORDS-1:0] s,
  output logic               cout,
  output logic               overflow
);

  localparam int unsigned N     = W * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic             op_q;
  logic             c;

  logic [W-1:0]     slice_r;
  logic             slice_co;
  logic             slice_ovf;

  nibble_alu #(.W(W)) u_alu (
    .a   (a_q[idx*W +: W]),
    .b   (b_q[idx*W +: W]),
    .cin (c),
    .op  (op_q),
    .s   (slice_r),
    .cout(slice_co),
    .ovf (slice_ovf)
  );

  // Sequencer: latch operands, walk the slices, then hold results with a one-cycle done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      s        <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      c        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            c     <= op;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          s[idx*W +: W] <= slice_r;
          c             <= slice_co;
          if (idx == IDX_LAST) begin
            cout     <= slice_co;
            overflow <= slice_ovf;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_seq.sv
// Directed and randomized checks of add_sub_seq against an arithmetic reference model.
module tb_add_sub_seq;

  localparam int unsigned W     = 4;
  localparam int unsigned WORDS = 4;
  localparam int unsigned N     = W * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         cout;
  logic         overflow;

  int tests = 0;
  int fails = 0;

  add_sub_seq #(.W(W), .WORDS(WORDS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .s       (s),
    .cout    (cout),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width arithmetic with signed-overflow from operand/result signs.
  task automatic ref_model(input logic [N-1:0] ra, input logic [N-1:0] rb, input logic rop,
                           output logic [N-1:0] rs, output logic rc, output logic rv);
    logic [N:0] full;
    if (rop) full = {1'b0, ra} + {1'b0, ~rb} + (N+1)'(1);
    else     full = {1'b0, ra} + {1'b0, rb};
    rs = full[N-1:0];
    rc = full[N];
    if (rop) rv = (ra[N-1] != rb[N-1]) && (rs[N-1] != ra[N-1]);
    else     rv = (ra[N-1] == rb[N-1]) && (rs[N-1] != ra[N-1]);
  endtask

  // Issue one operation; optionally pulse start again glitch_at edges after acceptance.
  task automatic do_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb_,
                       input logic top, input int glitch_at);
    logic [N-1:0] es;
    logic         ec;
    logic         ev;
    int           lat;
    int           busy_cycles;
    ref_model(ta, tb_, top, es, ec, ev);
    @(negedge clk);
    a = ta; b = tb_; op = top; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = N'($urandom); b = N'($urandom); op = ~top;
    lat = 0;
    busy_cycles = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cycles++;
      start = (lat == glitch_at);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (busy) busy_cycles++;
    check({tag, ".latency"}, 32'(lat), 32'(WORDS));
    check({tag, ".busy_cycles"}, 32'(busy_cycles), 32'(WORDS + 1));
    check({tag, ".s"}, 32'(s), 32'(es));
    check({tag, ".cout"}, 32'(cout), 32'(ec));
    check({tag, ".overflow"}, 32'(overflow), 32'(ev));
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(done), 32'(0));
    check({tag, ".busy_after"}, 32'(busy), 32'(0));
    check({tag, ".s_hold"}, 32'(s), 32'(es));
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    int           done_seen;

    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 32'(busy), 32'(0));
    check("reset.done", 32'(done), 32'(0));
    check("reset.s", 32'(s), 32'(0));
    check("reset.cout", 32'(cout), 32'(0));
    check("reset.ovf", 32'(overflow), 32'(0));
    rst = 1'b0;

    do_op("add_small", 16'h0001, 16'h0003, 1'b0, -1);
    do_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, -1);
    do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, -1);
    do_op("sub_borrow", 16'h0001, 16'h0003, 1'b1, -1);
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, -1);
    // start pulsed in RUN with fresh (random) operands must be ignored
    do_op("ignore_start", 16'h1234, 16'h1111, 1'b0, 1);
    check("ignore_start.value", 32'(s), 32'h2345);

    for (int i = 0; i < 24; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if (i < 4) rb = ra;
      do_op($sformatf("rand%0d", i), ra, rb, 1'($urandom), -1);
    end

    // Reset two cycles into an operation aborts it without a done pulse.
    @(negedge clk);
    a = 16'hABCD; b = 16'h1357; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort.busy", 32'(busy), 32'(0));
    check("abort.done", 32'(done), 32'(0));
    check("abort.s", 32'(s), 32'(0));
    check("abort.cout", 32'(cout), 32'(0));
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    check("abort.no_done", 32'(done_seen), 32'(0));

    do_op("after_abort", 16'h00FF, 16'h0F0F, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
